// File: rtl/str_unpack_if.sv
// rtl/str_unpack_if.sv - wide-word upstream and narrow-lane downstream stream bundle
interface str_unpack_if #(
    parameter int DATA_UP_WIDTH = 8,
    parameter int DATA_DN_WIDTH = 2
);
    localparam int DATA_NB   = DATA_UP_WIDTH / DATA_DN_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_NB) + 1;

    logic [DATA_UP_WIDTH-1:0] up_data;
    logic [CNT_WIDTH-1:0]     up_cnt;
    logic                     up_last;
    logic                     up_val;
    logic                     up_rdy;
    logic [DATA_DN_WIDTH-1:0] dn_data;
    logic                     dn_last;
    logic                     dn_val;
    logic                     dn_rdy;

    modport slave (
        input  up_data, up_cnt, up_last, up_val, dn_rdy,
        output up_rdy, dn_data, dn_last, dn_val
    );

    modport master (
        output up_data, up_cnt, up_last, up_val, dn_rdy,
        input  up_rdy, dn_data, dn_last, dn_val
    );
endinterface

// File: rtl/str_unpack.sv
// rtl/str_unpack.sv - splits lane-counted wide words into a narrow lane stream
module str_unpack #(
    parameter int DATA_UP_WIDTH = 8,
    parameter int DATA_DN_WIDTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    str_unpack_if.slave   bus
);
    localparam int DATA_NB   = DATA_UP_WIDTH / DATA_DN_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_NB) + 1;
    localparam logic [CNT_WIDTH-1:0] NB_CNT  = CNT_WIDTH'(DATA_NB);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

    logic [DATA_UP_WIDTH-1:0] hold_data;
    logic [DATA_UP_WIDTH-1:0] hold_data_nxt;
    logic [CNT_WIDTH-1:0]     rem;
    logic [CNT_WIDTH-1:0]     rem_nxt;
    logic                     hold_last;
    logic                     hold_last_nxt;

    logic                     busy;
    logic                     lane_xfer;
    logic                     fin_xfer;
    logic                     rdy;
    logic                     accept;
    logic [CNT_WIDTH-1:0]     eff_cnt;

    // Handshake qualifiers; BUSY whenever lanes remain, ready again on the last lane
    always_comb begin
        busy      = (rem != '0);
        lane_xfer = busy & bus.dn_rdy;
        fin_xfer  = lane_xfer & (rem == ONE_CNT);
        rdy       = rst & (~busy | fin_xfer);
        accept    = bus.up_val & rdy;
    end

    // Lane count of the incoming word: zero means full, oversize clamps to full
    always_comb begin
        eff_cnt = bus.up_cnt;
        if ((bus.up_cnt == '0) || (bus.up_cnt > NB_CNT)) begin
            eff_cnt = NB_CNT;
        end
    end

    // Holding state register, cleared asynchronously so a partial word is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data <= '0;
            rem       <= '0;
            hold_last <= 1'b0;
        end else begin
            hold_data <= hold_data_nxt;
            rem       <= rem_nxt;
            hold_last <= hold_last_nxt;
        end
    end

    // Next holding state; a new word takes priority over retiring the final lane
    always_comb begin
        hold_data_nxt = hold_data;
        rem_nxt       = rem;
        hold_last_nxt = hold_last;
        if (accept) begin
            hold_data_nxt = bus.up_data;
            rem_nxt       = eff_cnt;
            hold_last_nxt = bus.up_last;
        end else if (fin_xfer) begin
            rem_nxt       = '0;
            hold_last_nxt = 1'b0;
        end else if (lane_xfer) begin
            hold_data_nxt = hold_data >> DATA_DN_WIDTH;
            rem_nxt       = rem - ONE_CNT;
        end
    end

    // Outputs come straight from the holding registers
    always_comb begin
        bus.dn_val  = busy;
        bus.dn_data = hold_data[DATA_DN_WIDTH-1:0];
        bus.dn_last = hold_last & (rem == ONE_CNT);
        bus.up_rdy  = rdy;
    end
endmodule

// File: tb/tb_str_unpack.sv
// tb/tb_str_unpack.sv - self-checking bench for str_unpack
module tb_str_unpack;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    str_unpack_if #(.DATA_UP_WIDTH(8),  .DATA_DN_WIDTH(2)) a_if ();
    str_unpack_if #(.DATA_UP_WIDTH(32), .DATA_DN_WIDTH(8)) b_if ();

    str_unpack #(.DATA_UP_WIDTH(8),  .DATA_DN_WIDTH(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    str_unpack #(.DATA_UP_WIDTH(32), .DATA_DN_WIDTH(8)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference lane queues: every valid lane of every accepted word, in order
    int qa_d[$];
    bit qa_l[$];
    int qb_d[$];
    bit qb_l[$];

    // per-cycle observations of instance A for directed tables
    int log_v[$];
    int log_d[$];
    int log_l[$];
    int log_r[$];
    int tv[9];
    int td[9];
    int tl[9];
    int tr[9];

    int b_dn_lasts = 0;

    task automatic clear_log();
        log_v.delete(); log_d.delete(); log_l.delete(); log_r.delete();
    endtask

    task automatic cyc_a(input bit v, input logic [7:0] d, input logic [2:0] c, input bit l, input bit r);
        int n;
        @(negedge clk);
        a_if.up_val = v; a_if.up_data = d; a_if.up_cnt = c; a_if.up_last = l; a_if.dn_rdy = r;
        #2;
        log_v.push_back(int'(a_if.dn_val));
        log_d.push_back(int'(a_if.dn_data));
        log_l.push_back(int'(a_if.dn_last));
        log_r.push_back(int'(a_if.up_rdy));
        if (a_if.dn_val && r) begin
            check("a_lane_expected", (qa_d.size() != 0), 1);
            if (qa_d.size() != 0) begin
                check("a_lane_data", a_if.dn_data, qa_d.pop_front());
                check("a_lane_last", a_if.dn_last, qa_l.pop_front());
            end
        end
        if (v && a_if.up_rdy) begin
            n = (c == 0 || c > 4) ? 4 : int'(c);
            for (int i = 0; i < n; i++) begin
                qa_d.push_back(int'((d >> (2 * i)) & 8'h3));
                qa_l.push_back(l && (i == n - 1));
            end
        end
    endtask

    task automatic cyc_b(input bit v, input logic [31:0] d, input logic [2:0] c, input bit l, input bit r,
                         output bit acc);
        int n;
        @(negedge clk);
        b_if.up_val = v; b_if.up_data = d; b_if.up_cnt = c; b_if.up_last = l; b_if.dn_rdy = r;
        #2;
        acc = v && b_if.up_rdy;
        if (b_if.dn_val && r) begin
            if (b_if.dn_last) b_dn_lasts++;
            check("b_lane_expected", (qb_d.size() != 0), 1);
            if (qb_d.size() != 0) begin
                check("b_lane_data", b_if.dn_data, qb_d.pop_front());
                check("b_lane_last", b_if.dn_last, qb_l.pop_front());
            end
        end
        if (acc) begin
            n = (c == 0 || c > 4) ? 4 : int'(c);
            for (int i = 0; i < n; i++) begin
                qb_d.push_back(int'((d >> (8 * i)) & 32'hFF));
                qb_l.push_back(l && (i == n - 1));
            end
        end
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) cyc_a(0, 8'h00, 3'd0, 0, 1);
    endtask

    // compare the last 9 logged cycles against tv/td/tl/tr; -1 in td is don't-care
    task automatic chk_table(input string tag);
        check({tag, "_cycles"}, log_v.size(), 9);
        if (log_v.size() >= 9) begin
            for (int k = 0; k < 9; k++) begin
                check($sformatf("%s_val%0d", tag, k), log_v[k], tv[k]);
                if (td[k] >= 0) check($sformatf("%s_data%0d", tag, k), log_d[k], td[k]);
                check($sformatf("%s_last%0d", tag, k), log_l[k], tl[k]);
                check($sformatf("%s_uprdy%0d", tag, k), log_r[k], tr[k]);
            end
        end
        check({tag, "_drained"}, qa_d.size(), 0);
    endtask

    initial begin
        logic [2:0] cnts[3];
        logic [31:0] wd;
        logic [2:0]  wc;
        bit wl, shown, acc, r;
        int words, budget, up_lasts;

        rst = 1'b0;
        a_if.up_val = 0; a_if.up_data = '0; a_if.up_cnt = '0; a_if.up_last = 0; a_if.dn_rdy = 0;
        b_if.up_val = 0; b_if.up_data = '0; b_if.up_cnt = '0; b_if.up_last = 0; b_if.dn_rdy = 0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_a_val",  a_if.dn_val,  0);
        check("rst_a_last", a_if.dn_last, 0);
        check("rst_a_data", a_if.dn_data, 0);
        check("rst_a_uprdy", a_if.up_rdy, 0);
        check("rst_b_val",  b_if.dn_val,  0);
        check("rst_b_uprdy", b_if.up_rdy, 0);
        rst = 1'b1;
        #1;
        check("rel_a_uprdy", a_if.up_rdy, 1);

        // full word, plus clamp: counts 0, 7 and 4 must behave identically
        cnts = '{3'd0, 3'd7, 3'd4};
        foreach (cnts[j]) begin
            clear_log();
            cyc_a(1, 8'hE4, cnts[j], 1, 1);
            idle_a(8);
            tv = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
            td = '{-1, 0, 1, 2, 3, -1, -1, -1, -1};
            tl = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
            tr = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
            chk_table($sformatf("full_cnt%0d", cnts[j]));
        end

        // single lane of 0xFF
        clear_log();
        cyc_a(1, 8'hFF, 3'd1, 1, 1);
        idle_a(8);
        tv = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        td = '{-1, 3, -1, -1, -1, -1, -1, -1, -1};
        tl = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        tr = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        chk_table("one_lane");

        // partial word followed back-to-back by a full word
        clear_log();
        cyc_a(1, 8'hE4, 3'd3, 1, 1);
        cyc_a(0, 8'h00, 3'd0, 0, 1);
        cyc_a(0, 8'h00, 3'd0, 0, 1);
        cyc_a(1, 8'h1B, 3'd4, 0, 1);
        idle_a(5);
        tv = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        td = '{-1, 0, 1, 2, 3, 2, 1, 0, -1};
        tl = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        tr = '{1, 0, 0, 1, 0, 0, 0, 1, 1};
        chk_table("b2b");

        // backpressure pattern 1,0,0,1,1,0,1
        clear_log();
        cyc_a(1, 8'hE4, 3'd0, 1, 1);
        cyc_a(0, 8'h00, 3'd0, 0, 1);
        cyc_a(0, 8'h00, 3'd0, 0, 0);
        cyc_a(0, 8'h00, 3'd0, 0, 0);
        cyc_a(0, 8'h00, 3'd0, 0, 1);
        cyc_a(0, 8'h00, 3'd0, 0, 1);
        cyc_a(0, 8'h00, 3'd0, 0, 0);
        cyc_a(0, 8'h00, 3'd0, 0, 1);
        idle_a(1);
        tv = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        td = '{-1, 0, 1, 1, 1, 2, 3, 3, -1};
        tl = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
        tr = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
        chk_table("stall");

        // reset after lane 1 of 0xE4
        cyc_a(1, 8'hE4, 3'd0, 1, 1);
        cyc_a(0, 8'h00, 3'd0, 0, 1);
        cyc_a(0, 8'h00, 3'd0, 0, 1);
        check("pre_reset_val", a_if.dn_val, 1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_val",   a_if.dn_val,  0);
        check("mid_rst_last",  a_if.dn_last, 0);
        check("mid_rst_data",  a_if.dn_data, 0);
        check("mid_rst_uprdy", a_if.up_rdy,  0);
        qa_d.delete();
        qa_l.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_uprdy", a_if.up_rdy, 1);
        clear_log();
        cyc_a(1, 8'h1B, 3'd0, 0, 1);
        idle_a(8);
        tv = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
        td = '{-1, 3, 2, 1, 0, -1, -1, -1, -1};
        tl = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tr = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
        chk_table("after_rst");

        // randomized traffic on the 32-to-8 instance
        words = 0; budget = 0; up_lasts = 0; shown = 0;
        wd = '0; wc = '0; wl = 0;
        while (words < 1000 && budget < 30000) begin
            if (!shown) begin
                wd = $urandom;
                wc = 3'($urandom_range(0, 7));
                wl = 1'($urandom_range(0, 1));
                shown = ($urandom_range(0, 3) != 0);
            end
            r = ($urandom_range(0, 3) != 0);
            cyc_b(shown, wd, wc, wl, r, acc);
            if (acc) begin
                shown = 0;
                words++;
                if (wl) up_lasts++;
            end
            budget++;
        end
        check("rand_words_done", words, 1000);
        for (int i = 0; i < 20; i++) cyc_b(0, 32'h0, 3'd0, 0, 1, acc);
        check("rand_drained", qb_d.size(), 0);
        check("rand_last_count", b_dn_lasts, up_lasts);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
